// File: rtl/lsm_sequencer_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
package lsm_sequencer_pkg;

  localparam int LSM_LIST_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } lsm_state_t;

  // Addressing mode {P,U}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/lsm_sequencer_if.sv
// Control-unit <-> sequencer handshake bundle.
interface lsm_sequencer_if
  import lsm_sequencer_pkg::*;
#(
  parameter int LIST_W = LSM_LIST_W
);

  localparam int IDX_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);

  logic              start;
  logic [LIST_W-1:0] reg_list;
  logic [1:0]        mode;
  logic              step;
  logic              busy;
  logic              valid;
  logic [IDX_W-1:0]  reg_num;
  logic              last;
  logic              lsm_end;
  logic [CNT_W-1:0]  count;
  logic [7:0]        start_ofs;
  logic [7:0]        wb_ofs;

  modport master (
    output start, reg_list, mode, step,
    input  busy, valid, reg_num, last, lsm_end, count, start_ofs, wb_ofs
  );

  modport slave (
    input  start, reg_list, mode, step,
    output busy, valid, reg_num, last, lsm_end, count, start_ofs, wb_ofs
  );

endinterface

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit plus a found flag.
module lsm_prio_enc #(
  parameter int LIST_W = 16,
  parameter int IDX_W  = $clog2(LIST_W)
) (
  input  logic [LIST_W-1:0] mask,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // Scanning high-to-low lets the lowest set bit win the last assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Walks an LDM/STM register list lowest-first, one register per STEP.
module lsm_sequencer
  import lsm_sequencer_pkg::*;
#(
  parameter int LIST_W     = LSM_LIST_W,
  parameter int WORD_BYTES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  lsm_sequencer_if.slave   bus
);

  localparam int IDX_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);

  lsm_state_t        state_reg;
  logic [LIST_W-1:0] mask_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [7:0]        start_ofs_reg;
  logic [7:0]        wb_ofs_reg;

  logic [IDX_W-1:0]  cur_idx;
  logic              cur_found;
  logic [LIST_W-1:0] mask_rest;
  logic [CNT_W-1:0]  list_pop;
  logic [7:0]        span;
  logic [7:0]        start_ofs_next;
  logic [7:0]        wb_ofs_next;

  lsm_prio_enc #(
    .LIST_W (LIST_W),
    .IDX_W  (IDX_W)
  ) u_prio_enc (
    .mask  (mask_reg),
    .idx   (cur_idx),
    .found (cur_found)
  );

  // Clearing the lowest set bit is exactly the post-STEP mask.
  assign mask_rest = mask_reg & (mask_reg - LIST_W'(1));

  always_comb begin
    list_pop = '0;
    for (int i = 0; i < LIST_W; i++) begin
      list_pop = list_pop + CNT_W'(bus.reg_list[i]);
    end
  end

  assign span = 8'(WORD_BYTES) * 8'(list_pop);

  always_comb begin
    wb_ofs_next = bus.mode[0] ? span : (8'd0 - span);
    case (bus.mode)
      MODE_IA: start_ofs_next = 8'd0;
      MODE_IB: start_ofs_next = 8'(WORD_BYTES);
      MODE_DA: start_ofs_next = 8'(WORD_BYTES) - span;
      default: start_ofs_next = 8'd0 - span;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      count_reg     <= '0;
      start_ofs_reg <= '0;
      wb_ofs_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            mask_reg      <= bus.reg_list;
            count_reg     <= list_pop;
            start_ofs_reg <= start_ofs_next;
            wb_ofs_reg    <= wb_ofs_next;
            state_reg     <= (bus.reg_list != '0) ? ST_XFER : ST_DONE;
          end
        end
        ST_XFER: begin
          if (bus.step) begin
            mask_reg <= mask_rest;
            if (mask_rest == '0) state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.valid     = (state_reg == ST_XFER);
  assign bus.reg_num   = cur_idx;
  assign bus.last      = (state_reg == ST_XFER) && cur_found && (mask_rest == '0);
  assign bus.lsm_end   = (state_reg == ST_DONE);
  assign bus.count     = count_reg;
  assign bus.start_ofs = start_ofs_reg;
  assign bus.wb_ofs    = wb_ofs_reg;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer with hand-computed expectations.
module tb_lsm_sequencer;
  import lsm_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  lsm_sequencer_if #(.LIST_W(16)) bus_i ();

  lsm_sequencer #(.LIST_W(16), .WORD_BYTES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},  32'(bus_i.busy), 0);
    chk({tag, ".valid"}, 32'(bus_i.valid), 0);
    chk({tag, ".end"},   32'(bus_i.lsm_end), 0);
    chk({tag, ".last"},  32'(bus_i.last), 0);
  endtask

  task automatic begin_seq(input logic [15:0] lst, input logic [1:0] md);
    bus_i.start = 1'b1;
    bus_i.reg_list = lst;
    bus_i.mode = md;
    tick();
    bus_i.start = 1'b0;
  endtask

  initial begin
    bus_i.start = 1'b0;
    bus_i.reg_list = '0;
    bus_i.mode = 2'b00;
    bus_i.step = 1'b0;

    // Reset state
    tick(); tick();
    chk_idle("rst");
    chk("rst.reg_num", 32'(bus_i.reg_num), 0);
    chk("rst.count",   32'(bus_i.count), 0);
    chk("rst.sofs",    32'(bus_i.start_ofs), 0);
    chk("rst.wofs",    32'(bus_i.wb_ofs), 0);
    reset_n = 1'b1;
    tick();

    // IA list 8011
    begin_seq(16'h8011, MODE_IA);
    chk("ia.valid", 32'(bus_i.valid), 1);
    chk("ia.count", 32'(bus_i.count), 3);
    chk("ia.sofs",  32'(bus_i.start_ofs), 32'h00);
    chk("ia.wofs",  32'(bus_i.wb_ofs), 32'h0C);
    chk("ia.r0",    32'(bus_i.reg_num), 0);
    chk("ia.last0", 32'(bus_i.last), 0);
    bus_i.step = 1'b1;
    tick();
    chk("ia.r4",    32'(bus_i.reg_num), 4);
    chk("ia.last4", 32'(bus_i.last), 0);
    tick();
    chk("ia.r15",    32'(bus_i.reg_num), 15);
    chk("ia.last15", 32'(bus_i.last), 1);
    tick();
    bus_i.step = 1'b0;
    chk("ia.end",   32'(bus_i.lsm_end), 1);
    chk("ia.busyD", 32'(bus_i.busy), 1);
    chk("ia.validD", 32'(bus_i.valid), 0);
    tick();
    chk_idle("ia.idle");
    chk("ia.hold",  32'(bus_i.count), 3);

    // STEP in IDLE ignored
    bus_i.step = 1'b1;
    tick();
    bus_i.step = 1'b0;
    chk_idle("stepidle");

    // DB list 00F0
    begin_seq(16'h00F0, MODE_DB);
    chk("db.count", 32'(bus_i.count), 4);
    chk("db.sofs",  32'(bus_i.start_ofs), 32'hF0);
    chk("db.wofs",  32'(bus_i.wb_ofs), 32'hF0);
    for (int k = 0; k < 4; k++) begin
      chk("db.reg", 32'(bus_i.reg_num), 32'(4 + k));
      chk("db.last", 32'(bus_i.last), (k == 3) ? 1 : 0);
      bus_i.step = 1'b1;
      tick();
      bus_i.step = 1'b0;
    end
    chk("db.end", 32'(bus_i.lsm_end), 1);
    tick();
    chk_idle("db.idle");

    // Empty list
    begin_seq(16'h0000, MODE_IA);
    chk("emp.valid", 32'(bus_i.valid), 0);
    chk("emp.busy",  32'(bus_i.busy), 1);
    chk("emp.end",   32'(bus_i.lsm_end), 1);
    chk("emp.count", 32'(bus_i.count), 0);
    chk("emp.wofs",  32'(bus_i.wb_ofs), 0);
    tick();
    chk_idle("emp.idle");

    // IB full list with a stall mid-list
    begin_seq(16'hFFFF, MODE_IB);
    chk("ib.count", 32'(bus_i.count), 16);
    chk("ib.sofs",  32'(bus_i.start_ofs), 32'h04);
    chk("ib.wofs",  32'(bus_i.wb_ofs), 32'h40);
    for (int k = 0; k < 8; k++) begin
      chk("ib.reg", 32'(bus_i.reg_num), 32'(k));
      bus_i.step = 1'b1;
      tick();
      bus_i.step = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      chk("ib.stall", 32'(bus_i.reg_num), 8);
      chk("ib.stallv", 32'(bus_i.valid), 1);
      chk("ib.stalll", 32'(bus_i.last), 0);
      tick();
    end
    for (int k = 8; k < 16; k++) begin
      chk("ib.reg", 32'(bus_i.reg_num), 32'(k));
      chk("ib.last", 32'(bus_i.last), (k == 15) ? 1 : 0);
      bus_i.step = 1'b1;
      tick();
      bus_i.step = 1'b0;
    end
    chk("ib.end", 32'(bus_i.lsm_end), 1);
    tick();
    chk_idle("ib.idle");

    // START during XFER and DONE is ignored
    begin_seq(16'h0003, MODE_IA);
    chk("ign.r0", 32'(bus_i.reg_num), 0);
    bus_i.start = 1'b1;
    bus_i.reg_list = 16'hFFFF;
    bus_i.mode = MODE_IB;
    bus_i.step = 1'b1;
    tick();
    chk("ign.r1",    32'(bus_i.reg_num), 1);
    chk("ign.count", 32'(bus_i.count), 2);
    chk("ign.wofs",  32'(bus_i.wb_ofs), 32'h08);
    tick();
    bus_i.step = 1'b0;
    chk("ign.end",   32'(bus_i.lsm_end), 1);
    tick();
    bus_i.start = 1'b0;
    chk_idle("ign.idle");
    chk("ign.count2", 32'(bus_i.count), 2);
    chk("ign.sofs",   32'(bus_i.start_ofs), 32'h00);

    // DA list 0007 with reset mid-sequence
    begin_seq(16'h0007, MODE_DA);
    chk("da.sofs", 32'(bus_i.start_ofs), 32'hF8);
    chk("da.wofs", 32'(bus_i.wb_ofs), 32'hF4);
    bus_i.step = 1'b1;
    tick(); tick();
    bus_i.step = 1'b0;
    chk("da.r2", 32'(bus_i.reg_num), 2);
    reset_n = 1'b0;
    bus_i.step = 1'b1;
    bus_i.start = 1'b1;
    tick();
    reset_n = 1'b1;
    bus_i.step = 1'b0;
    bus_i.start = 1'b0;
    chk_idle("rst2");
    chk("rst2.reg", 32'(bus_i.reg_num), 0);
    chk("rst2.count", 32'(bus_i.count), 0);
    chk("rst2.sofs",  32'(bus_i.start_ofs), 0);
    chk("rst2.wofs",  32'(bus_i.wb_ofs), 0);
    tick();
    chk_idle("rst2.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsm_sequencer.md
LSM_SEQUENCER -- requirements
Module: lsm_sequencer

Interface
REQ-001 Parameter: LIST_W, 16, register-list width (one bit per register R0..R15).
REQ-002 Parameter: WORD_BYTES, 4, byte stride per transferred register.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  reset, synchronous, active-low.
REQ-005 START  input  1  one-cycle request from control unit (LSM_EN) to begin an LDM/STM sequence.
REQ-006 REG_LIST  input  16  register list (IR[15:0]), sampled only on accepted START.
REQ-007 MODE  input  2  addressing mode {P,U} (IR[24:23]): 00=DA, 01=IA, 10=DB, 11=IB; sampled on accepted START.
REQ-008 STEP  input  1  current register transfer completed (memory MOC seen); advance.
REQ-009 BUSY  output  1  high in XFER and DONE.
REQ-010 VALID  output  1  high in XFER only; REG_NUM meaningful.
REQ-011 REG_NUM  output  4  register number of current transfer (drives register-file/mux address).
REQ-012 LAST  output  1  VALID and current register is the final one in the list.
REQ-013 LSM_END  output  1  one-cycle pulse marking sequence end (control unit LSM_END).
REQ-014 COUNT  output  5  number of set bits in the latched list (0..16).
REQ-015 START_OFS  output  8  signed byte offset from Rn to first transfer address.
REQ-016 WB_OFS  output  8  signed byte offset from Rn to written-back base.

Function
REQ-017 States: IDLE, XFER, DONE; encoding from shared package.
REQ-018 IDLE + START: latch REG_LIST into pending mask, latch MODE, compute COUNT; next state XFER if list nonzero, else DONE.
REQ-019 START while BUSY is ignored; latched values unchanged.
REQ-020 REG_NUM = index of lowest set bit of pending mask (ascending order, R0 first), combinational from mask.
REQ-021 First VALID cycle is the cycle after START edge (latency 1).
REQ-022 XFER + STEP: clear bit REG_NUM in mask; if mask becomes zero, next state DONE, else stay XFER with next lowest register.
REQ-023 XFER without STEP: hold REG_NUM, VALID, LAST stable indefinitely.
REQ-024 STEP in IDLE or DONE is ignored.
REQ-025 DONE lasts exactly one cycle with LSM_END=1, then IDLE; START in DONE ignored.
REQ-026 Empty list: START -> DONE -> IDLE; LSM_END one pulse, VALID never asserted, COUNT=0.
REQ-027 START_OFS (n=COUNT, s=WORD_BYTES): IA 0; IB +s; DA -s*n+s; DB -s*n; two's complement, 8 bits.
REQ-028 WB_OFS: +s*n for U=1, -s*n for U=0; range -64..+64 fits 8 bits.
REQ-029 COUNT, START_OFS, WB_OFS hold latched-sequence values from START until the next accepted START.
REQ-030 LAST = VALID and popcount(mask)==1.

Reset
REQ-031 RESET_N low at a rising edge: state IDLE, mask 0, MODE 00, COUNT 0; all outputs 0.
REQ-032 Reset mid-sequence aborts immediately; no LSM_END pulse generated.
REQ-033 Reset overrides START and STEP in the same cycle.

Structure
REQ-034 Shared package holds: state enum, MODE constants (DA/IA/DB/IB), LIST_W default.
REQ-035 One sub-module: lsm_prio_enc (16-bit lowest-set-bit encoder with found flag), combinational.
REQ-036 Popcount and offset arithmetic inline in lsm_sequencer; no memory or register-file logic inside.

Verification
REQ-037 Reset, then START with REG_LIST=16'h8011, MODE=01 -> COUNT=3, START_OFS=0, WB_OFS=+12; REG_NUM 0,4,15 on successive STEPs, LAST only at 15, LSM_END one cycle after third STEP.
REQ-038 REG_LIST=16'h00F0, MODE=10 (DB) -> COUNT=4, START_OFS=-16 (8'hF0), WB_OFS=-16; REG_NUM 4,5,6,7.
REQ-039 REG_LIST=16'h0000 -> VALID never high, LSM_END pulses cycle after START, BUSY high for exactly one cycle.
REQ-040 REG_LIST=16'hFFFF, MODE=11, STEP held low 5 cycles mid-list -> REG_NUM stable; COUNT=16, START_OFS=+4, WB_OFS=+64.
REQ-041 Second START during XFER of 16'h0003 -> ignored, sequence completes R0,R1 unchanged.
REQ-042 RESET_N low while REG_NUM=2 of 16'h0007 -> next cycle IDLE, all outputs 0, no LSM_END.
